// File: rtl/fir_sched_pkg.sv
// Shared types and constants for the FIR sequencer slice.
// Optional tlast checking is enabled with FIR_SCHED_TLAST_CHK_EN.
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    WAIT_IN = 3'd2,
    MAC     = 3'd3,
    DRAIN   = 3'd4,
    OUT     = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam int NUM_TAP_DEF = 11;
  localparam int DW_DEF      = 32;
  localparam int AW_DEF      = 4;

  // Bit positions of the AXI-Lite control register
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_DONE_BIT  = 1;
  localparam int CTRL_IDLE_BIT  = 2;

endpackage

// File: rtl/fir_sched_if.sv
// AXI-Stream input/output handshake bundle between the sequencer and its
// stream neighbours; master is the stream environment, slave is fir_sched.
interface fir_sched_if
  import fir_pkg::*;
#(
  parameter int DW = DW_DEF
);

  logic          ss_tvalid;
  logic [DW-1:0] ss_tdata;
  logic          ss_tlast;
  logic          ss_tready;
  logic          sm_tready;
  logic          sm_tvalid;
  logic [DW-1:0] sm_tdata;
  logic          sm_tlast;

  modport master (
    output ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    input  ss_tready, sm_tvalid, sm_tdata, sm_tlast
  );

  modport slave (
    input  ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    output ss_tready, sm_tvalid, sm_tdata, sm_tlast
  );

endinterface

// File: rtl/fir_sched_addr_gen.sv
// Circular-buffer address generation: write pointer, tap index k and the
// data read address (wr_ptr - k) mod NUM_TAP.
module fir_addr_gen
  import fir_pkg::*;
#(
  parameter int NUM_TAP = NUM_TAP_DEF,
  parameter int AW      = AW_DEF
)(
  input  logic          axis_clk,
  input  logic          axis_rst,
  input  logic          k_clr,
  input  logic          k_inc,
  input  logic          ptr_adv,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] k,
  output logic [AW-1:0] rd_addr,
  output logic          k_last
);

  localparam logic [AW-1:0] NT_A   = AW'(NUM_TAP);
  localparam logic [AW-1:0] LAST_A = AW'(NUM_TAP - 1);

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] k_r;
  logic [AW-1:0] rd_addr_s;

  assign k_last  = (k_r == LAST_A);
  assign wr_ptr  = wr_ptr_r;
  assign k       = k_r;
  assign rd_addr = rd_addr_s;

  // Pointer and tap index both wrap at NUM_TAP-1
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      wr_ptr_r <= {AW{1'b0}};
      k_r      <= {AW{1'b0}};
    end else begin
      if (k_clr) begin
        k_r <= {AW{1'b0}};
      end else if (k_inc) begin
        k_r <= k_last ? {AW{1'b0}} : k_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        k_r <= k_r;
      end
      if (ptr_adv) begin
        wr_ptr_r <= (wr_ptr_r == LAST_A) ? {AW{1'b0}}
                                         : wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
    end
  end

  // Modulo subtraction; the AW-bit wrap of wr_ptr + NUM_TAP is harmless
  always_comb begin
    if (wr_ptr_r >= k_r) begin
      rd_addr_s = wr_ptr_r - k_r;
    end else begin
      rd_addr_s = wr_ptr_r + NT_A - k_r;
    end
  end

endmodule

// File: rtl/fir_sched.sv
// Sequencer for the single-MAC FIR: ap protocol, SRAM addressing, MAC control
// and stream gating. Define FIR_SCHED_TLAST_CHK_EN to enable err_tlast.
module fir_sched
  import fir_pkg::*;
#(
  parameter int NUM_TAP = NUM_TAP_DEF,
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF
)(
  input  logic          axis_clk,
  input  logic          axis_rst,
  input  logic          ap_start,
  input  logic [31:0]   data_length,
  input  logic          ap_done_clr,
  output logic          ap_idle,
  output logic          ap_done,
  output logic          tap_lock,
  fir_sched_if.slave    axis,
  output logic [AW-1:0] tap_addr,
  output logic [AW-1:0] data_addr,
  output logic          data_we,
  output logic [DW-1:0] data_wdata,
  output logic          mac_clr,
  output logic          mac_en,
  input  logic [DW-1:0] acc_in,
  output logic          err_tlast
);

  state_t        state_r;
  logic [31:0]   len_r;
  logic [31:0]   count_r;
  logic          drain_r;
  logic          ap_idle_r;
  logic          ap_done_r;
  logic          tap_lock_r;
  logic          ss_tready_r;
  logic          sm_tvalid_r;
  logic          sm_tlast_r;
  logic [DW-1:0] sm_tdata_r;
  logic          mac_en_r;
  logic          mac_clr_r;

  logic          hs_in_s;
  logic          hs_out_s;
  logic          is_last_s;
  logic          k_clr_s;
  logic          k_inc_s;
  logic          ptr_adv_s;
  logic          k_last_s;
  logic [AW-1:0] wr_ptr_s;
  logic [AW-1:0] k_s;
  logic [AW-1:0] rd_addr_s;
  logic [AW-1:0] tap_addr_s;
  logic [AW-1:0] data_addr_s;
  logic          data_we_s;
  logic [DW-1:0] data_wdata_s;

  assign hs_in_s   = axis.ss_tvalid & ss_tready_r;
  assign hs_out_s  = axis.sm_tready & sm_tvalid_r;
  assign is_last_s = (count_r == (len_r - 32'd1));

`ifdef FIR_SCHED_TLAST_CHK_EN
  logic err_tlast_r;
  assign err_tlast = err_tlast_r;
`else
  logic unused_tlast_s;
  assign unused_tlast_s = axis.ss_tlast;
  assign err_tlast      = 1'b0;
`endif

  fir_addr_gen #(
    .NUM_TAP (NUM_TAP),
    .AW      (AW)
  ) u_addr_gen (
    .axis_clk (axis_clk),
    .axis_rst (axis_rst),
    .k_clr    (k_clr_s),
    .k_inc    (k_inc_s),
    .ptr_adv  (ptr_adv_s),
    .wr_ptr   (wr_ptr_s),
    .k        (k_s),
    .rd_addr  (rd_addr_s),
    .k_last   (k_last_s)
  );

  // SRAM ports and address-generator steering for the current phase
  always_comb begin
    tap_addr_s   = {AW{1'b0}};
    data_addr_s  = {AW{1'b0}};
    data_we_s    = 1'b0;
    data_wdata_s = {DW{1'b0}};
    k_clr_s      = 1'b0;
    k_inc_s      = 1'b0;
    ptr_adv_s    = 1'b0;
    case (state_r)
      IDLE: begin
        k_clr_s = 1'b1;
      end
      CLEAR: begin
        data_we_s   = 1'b1;
        data_addr_s = k_s;
        k_inc_s     = 1'b1;
      end
      WAIT_IN: begin
        data_addr_s = wr_ptr_s;
        if (hs_in_s) begin
          data_we_s    = 1'b1;
          data_wdata_s = axis.ss_tdata;
        end else begin
          data_we_s    = 1'b0;
        end
      end
      MAC: begin
        tap_addr_s  = k_s;
        data_addr_s = rd_addr_s;
        k_inc_s     = 1'b1;
      end
      DRAIN: begin
        ptr_adv_s = ~drain_r;
      end
      default: begin
        k_clr_s = 1'b0;
      end
    endcase
  end

  // Main sequencer: state, counters and all registered handshake outputs
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_r     <= IDLE;
      len_r       <= 32'd0;
      count_r     <= 32'd0;
      drain_r     <= 1'b0;
      ap_idle_r   <= 1'b1;
      ap_done_r   <= 1'b0;
      tap_lock_r  <= 1'b0;
      ss_tready_r <= 1'b0;
      sm_tvalid_r <= 1'b0;
      sm_tlast_r  <= 1'b0;
      sm_tdata_r  <= {DW{1'b0}};
      mac_en_r    <= 1'b0;
      mac_clr_r   <= 1'b0;
`ifdef FIR_SCHED_TLAST_CHK_EN
      err_tlast_r <= 1'b0;
`endif
    end else begin
      // Read data lags the address by one cycle, so MAC strobes lag MAC state
      mac_en_r  <= (state_r == MAC);
      mac_clr_r <= (state_r == MAC) && (k_s == {AW{1'b0}});
      if (ap_done_clr) begin
        ap_done_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (ap_start && ap_idle_r) begin
            len_r      <= data_length;
            count_r    <= 32'd0;
            ap_done_r  <= 1'b0;
            ap_idle_r  <= 1'b0;
            tap_lock_r <= 1'b1;
            state_r    <= CLEAR;
`ifdef FIR_SCHED_TLAST_CHK_EN
            err_tlast_r <= 1'b0;
`endif
          end
        end
        CLEAR: begin
          if (k_last_s) begin
            if (len_r == 32'd0) begin
              state_r    <= DONE;
              ap_done_r  <= 1'b1;
              ap_idle_r  <= 1'b1;
              tap_lock_r <= 1'b0;
            end else begin
              state_r     <= WAIT_IN;
              ss_tready_r <= 1'b1;
            end
          end
        end
        WAIT_IN: begin
          if (hs_in_s) begin
            ss_tready_r <= 1'b0;
            state_r     <= MAC;
`ifdef FIR_SCHED_TLAST_CHK_EN
            if (axis.ss_tlast != is_last_s) begin
              err_tlast_r <= 1'b1;
            end
`endif
          end
        end
        MAC: begin
          if (k_last_s) begin
            drain_r <= 1'b0;
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_r) begin
            sm_tdata_r  <= acc_in;
            sm_tlast_r  <= is_last_s;
            sm_tvalid_r <= 1'b1;
            state_r     <= OUT;
          end else begin
            drain_r <= 1'b1;
          end
        end
        OUT: begin
          if (hs_out_s) begin
            count_r     <= count_r + 32'd1;
            sm_tvalid_r <= 1'b0;
            sm_tlast_r  <= 1'b0;
            if (is_last_s) begin
              state_r    <= DONE;
              ap_done_r  <= 1'b1;
              ap_idle_r  <= 1'b1;
              tap_lock_r <= 1'b0;
            end else begin
              state_r     <= WAIT_IN;
              ss_tready_r <= 1'b1;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign ap_idle        = ap_idle_r;
  assign ap_done        = ap_done_r;
  assign tap_lock       = tap_lock_r;
  assign axis.ss_tready = ss_tready_r;
  assign axis.sm_tvalid = sm_tvalid_r;
  assign axis.sm_tdata  = sm_tdata_r;
  assign axis.sm_tlast  = sm_tlast_r;
  assign tap_addr       = tap_addr_s;
  assign data_addr      = data_addr_s;
  assign data_we        = data_we_s;
  assign data_wdata     = data_wdata_s;
  assign mac_clr        = mac_clr_r;
  assign mac_en         = mac_en_r;

endmodule

// File: tb/tb_fir_sched.sv
// Directed-vector bench for fir_sched with tap/data SRAM and MAC models and
// a scoreboard monitor on the output stream.
module tb_fir_sched;

  localparam int NT = 11;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        axis_clk = 1'b0;
  logic        axis_rst;
  logic        ap_start;
  logic [31:0] data_length;
  logic        ap_done_clr;
  logic        ap_idle;
  logic        ap_done;
  logic        tap_lock;
  logic [3:0]  tap_addr;
  logic [3:0]  data_addr;
  logic        data_we;
  logic [31:0] data_wdata;
  logic        mac_clr;
  logic        mac_en;
  logic [31:0] acc;
  logic        err_tlast;

  logic [31:0] tap_mem [16];
  logic [31:0] data_mem [16];
  logic [31:0] tap_rdata;
  logic [31:0] data_rdata;
  logic [31:0] prod;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   mac_cnt = 0;
  int   we_cnt  = 0;

  fir_sched_if #(.DW(32)) axis_if ();

  fir_sched u_dut (
    .axis_clk    (axis_clk),
    .axis_rst    (axis_rst),
    .ap_start    (ap_start),
    .data_length (data_length),
    .ap_done_clr (ap_done_clr),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .tap_lock    (tap_lock),
    .axis        (axis_if),
    .tap_addr    (tap_addr),
    .data_addr   (data_addr),
    .data_we     (data_we),
    .data_wdata  (data_wdata),
    .mac_clr     (mac_clr),
    .mac_en      (mac_en),
    .acc_in      (acc),
    .err_tlast   (err_tlast)
  );

  always #5 axis_clk = ~axis_clk;

  // SRAMs with one-cycle read latency and the wrapping MAC
  assign prod = tap_rdata * data_rdata;
  always @(posedge axis_clk) begin
    tap_rdata  <= tap_mem[tap_addr];
    data_rdata <= data_mem[data_addr];
    if (data_we) data_mem[data_addr] <= data_wdata;
    if (axis_rst) acc <= 32'd0;
    else if (mac_en) acc <= mac_clr ? prod : acc + prod;
  end

  always @(negedge axis_clk) begin
    if (mac_en) mac_cnt = mac_cnt + 1;
    if (data_we) we_cnt = we_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Output monitor: pops one expected word per sm handshake
  always @(negedge axis_clk) begin
    if (axis_if.sm_tvalid === 1'b1 && axis_if.sm_tready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL out_unexpected: got %0h want no output", axis_if.sm_tdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", axis_if.sm_tdata, e.data);
        chk("out_last", {31'd0, axis_if.sm_tlast}, {31'd0, e.last});
      end
    end
  end

  task automatic push(input logic [31:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic set_taps(input logic [31:0] ofs);
    for (int i = 0; i < 16; i++) tap_mem[i] = (i < NT) ? 32'(i) + ofs : 32'd0;
  endtask

  task automatic start(input logic [31:0] len);
    @(posedge axis_clk); #1;
    data_length = len;
    ap_start    = 1'b1;
    @(posedge axis_clk); #1;
    ap_start    = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    axis_if.ss_tvalid = 1'b1;
    axis_if.ss_tdata  = d;
    axis_if.ss_tlast  = l;
    @(negedge axis_clk);
    while (axis_if.ss_tready !== 1'b1 && n < 200) begin
      @(negedge axis_clk);
      n++;
    end
    chk("send_ready", {31'd0, axis_if.ss_tready}, 32'd1);
    @(posedge axis_clk); #1;
    axis_if.ss_tvalid = 1'b0;
    axis_if.ss_tlast  = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (ap_done !== 1'b1 && n < 300) begin
      @(negedge axis_clk);
      n++;
    end
    chk(nm, {31'd0, ap_done}, 32'd1);
  endtask

  task automatic run_basic(input logic first_last, input string nm);
    push(32'd0, 1'b0);
    push(32'd1, 1'b0);
    push(32'd4, 1'b1);
    start(32'd3);
    @(negedge axis_clk);
    chk({nm, "_tap_lock"}, {31'd0, tap_lock}, 32'd1);
    chk({nm, "_idle_low"}, {31'd0, ap_idle}, 32'd0);
    send(32'd1, first_last);
    send(32'd2, 1'b0);
    send(32'd3, 1'b1);
    wait_done({nm, "_done"});
    chk({nm, "_idle"}, {31'd0, ap_idle}, 32'd1);
    chk({nm, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int mac_base;
    int we_base;
    int n;
    axis_rst          = 1'b1;
    ap_start          = 1'b0;
    data_length       = 32'd0;
    ap_done_clr       = 1'b0;
    axis_if.ss_tvalid = 1'b0;
    axis_if.ss_tdata  = 32'd0;
    axis_if.ss_tlast  = 1'b0;
    axis_if.sm_tready = 1'b1;
    set_taps(32'd0);
    repeat (3) @(posedge axis_clk);
    #1 axis_rst = 1'b0;

    @(negedge axis_clk);
    chk("rst_idle", {31'd0, ap_idle}, 32'd1);
    chk("rst_done", {31'd0, ap_done}, 32'd0);
    chk("rst_tap_lock", {31'd0, tap_lock}, 32'd0);
    chk("rst_ss_tready", {31'd0, axis_if.ss_tready}, 32'd0);
    chk("rst_sm_tvalid", {31'd0, axis_if.sm_tvalid}, 32'd0);
    chk("rst_mac_en", {31'd0, mac_en}, 32'd0);
    chk("rst_data_we", {31'd0, data_we}, 32'd0);

    // taps 0..10, inputs 1,2,3 -> 0,1,4
    mac_base = mac_cnt;
    we_base  = we_cnt;
    run_basic(1'b0, "run1");
    chk("run1_mac_cycles", 32'(mac_cnt - mac_base), 32'd33);
    chk("run1_ram_writes", 32'(we_cnt - we_base), 32'd14);
    chk("run1_err_tlast", {31'd0, err_tlast}, 32'd0);

    // impulse through taps k+1, 12 samples wraps the write pointer
    set_taps(32'd1);
    for (int i = 0; i < 11; i++) push(32'(i + 1), 1'b0);
    push(32'd0, 1'b1);
    start(32'd12);
    for (int i = 0; i < 12; i++) send((i == 0) ? 32'd1 : 32'd0, (i == 11));
    wait_done("run2_done");
    chk("run2_q_empty", 32'(exp_q.size()), 32'd0);

    // output stall: 5, 7 with taps k+1 -> 5, 17
    push(32'd5, 1'b0);
    push(32'd17, 1'b1);
    axis_if.sm_tready = 1'b0;
    start(32'd2);
    send(32'd5, 1'b0);
    n = 0;
    while (axis_if.sm_tvalid !== 1'b1 && n < 100) begin
      @(negedge axis_clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, axis_if.sm_tvalid}, 32'd1);
      chk("stall_data", axis_if.sm_tdata, 32'd5);
      chk("stall_last", {31'd0, axis_if.sm_tlast}, 32'd0);
      chk("stall_ss_tready", {31'd0, axis_if.ss_tready}, 32'd0);
      @(negedge axis_clk);
    end
    @(posedge axis_clk); #1;
    axis_if.sm_tready = 1'b1;
    send(32'd7, 1'b1);
    wait_done("stall_done");
    chk("stall_q_empty", 32'(exp_q.size()), 32'd0);

    // start while busy is ignored; length 1 gives a single output
    push(32'd9, 1'b1);
    start(32'd1);
    data_length = 32'd5;
    ap_start    = 1'b1;
    @(posedge axis_clk); #1;
    ap_start    = 1'b0;
    @(negedge axis_clk);
    chk("busy_idle", {31'd0, ap_idle}, 32'd0);
    send(32'd9, 1'b1);
    wait_done("busy_done");
    repeat (4) @(negedge axis_clk);
    chk("busy_q_empty", 32'(exp_q.size()), 32'd0);
    chk("busy_still_idle", {31'd0, ap_idle}, 32'd1);

    @(posedge axis_clk); #1 ap_done_clr = 1'b1;
    @(posedge axis_clk); #1 ap_done_clr = 1'b0;
    @(negedge axis_clk);
    chk("done_clr", {31'd0, ap_done}, 32'd0);

    // length 0: clr held over DONE entry, set must win after NUM_TAP clears
    we_base     = we_cnt;
    ap_done_clr = 1'b1;
    start(32'd0);
    n = 0;
    while (ap_done !== 1'b1 && n < 100) begin
      @(negedge axis_clk);
      n++;
    end
    ap_done_clr = 1'b0;
    chk("len0_latency", 32'(n), 32'(NT + 1));
    chk("len0_ram_writes", 32'(we_cnt - we_base), 32'(NT));
    @(negedge axis_clk);
    chk("len0_done_sticky", {31'd0, ap_done}, 32'd1);
    chk("len0_idle", {31'd0, ap_idle}, 32'd1);

    // reset in the middle of MAC, then the basic run again
    set_taps(32'd0);
    start(32'd3);
    send(32'd1, 1'b0);
    n = 0;
    while (mac_en !== 1'b1 && n < 50) begin
      @(negedge axis_clk);
      n++;
    end
    chk("mid_mac_en", {31'd0, mac_en}, 32'd1);
    @(posedge axis_clk); #1 axis_rst = 1'b1;
    @(posedge axis_clk); #1 axis_rst = 1'b0;
    @(negedge axis_clk);
    chk("mid_rst_mac_en", {31'd0, mac_en}, 32'd0);
    chk("mid_rst_sm_tvalid", {31'd0, axis_if.sm_tvalid}, 32'd0);
    chk("mid_rst_idle", {31'd0, ap_idle}, 32'd1);
    chk("mid_rst_tap_lock", {31'd0, tap_lock}, 32'd0);
    chk("mid_rst_data_we", {31'd0, data_we}, 32'd0);
    run_basic(1'b0, "rerun");

    // tlast asserted on the first of three samples
    run_basic(1'b1, "tlast");
`ifdef FIR_SCHED_TLAST_CHK_EN
    chk("tlast_err_set", {31'd0, err_tlast}, 32'd1);
`else
    chk("tlast_err_off", {31'd0, err_tlast}, 32'd0);
`endif
    start(32'd0);
    wait_done("tlast_restart_done");
    chk("tlast_err_cleared", {31'd0, err_tlast}, 32'd0);

    repeat (3) @(negedge axis_clk);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
